// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port between
// ALU writeback (A) and load writeback (B), with a registered write stage.
module regfile_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              last_grant
);

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_last_grant;

    logic              w_open;
    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;

    // Grants depend only on valid, stall, reset and the pointer.
    assign w_open    = reset & ~stall;
    assign w_grant_a = w_open & a_valid & (~b_valid | r_last_grant);
    assign w_grant_b = w_open & b_valid & (~a_valid | ~r_last_grant);
    assign w_xfer    = w_grant_a | w_grant_b;

    always_comb begin
        w_sel_addr = a_addr;
        w_sel_data = a_data;
        unique case (1'b1)
            w_grant_b: begin
                w_sel_addr = b_addr;
                w_sel_data = b_data;
            end
            default: begin
                w_sel_addr = a_addr;
                w_sel_data = a_data;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_last_grant <= 1'b1;
        end else if (w_xfer) begin
            r_wr_en      <= |w_sel_addr;
            r_wr_addr    <= w_sel_addr;
            r_wr_data    <= w_sel_data;
            r_last_grant <= w_grant_b;
        end else begin
            r_wr_en <= 1'b0;
        end
    end

    assign a_ready    = w_grant_a;
    assign b_ready    = w_grant_b;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign last_grant = r_last_grant;

endmodule
